// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle logic/arith/shift/compare ops,
// shift-add multiply and restoring divide, one transaction in flight at a time.
module alu_mc #(
   parameter int N  = 32,
   parameter int SW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   ctrl,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [N-1:0] result_hi,
   output logic         zero,
   output logic         negative,
   output logic         overflow,
   output logic         carry
);

   // state | meaning
   // IDLE  | in_ready high, waiting for a request
   // BUSY  | mul/divu/remu iterating one bit per cycle
   // DONE  | result valid and frozen until out_ready
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOTA = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_SHR  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_EQ   = 4'b1001;
   localparam logic [3:0] OP_LTU  = 4'b1010;
   localparam logic [3:0] OP_GTU  = 4'b1011;
   localparam logic [3:0] OP_MUL  = 4'b1100;
   localparam logic [3:0] OP_DIVU = 4'b1101;
   localparam logic [3:0] OP_REMU = 4'b1110;
   localparam logic [3:0] OP_SLT  = 4'b1111;

   if (N < 4 || N > 32) begin : g_n_range
      $warning("alu_mc: N=%0d outside supported range 4..32", N);
   end

   state_t         state_q;
   logic           in_ready_q, out_valid_q;
   logic [3:0]     op_q;
   logic [N-1:0]   b_q, hi_q, lo_q;
   logic [SW-1:0]  cnt_q;
   logic [N-1:0]   result_q, result_hi_q;
   logic           zero_q, neg_q, ovf_q, carry_q;

   logic [N:0]         sum_ext, diff_ext;
   logic [SW-1:0]      shamt;
   logic               sh_big;
   logic signed [N-1:0] sra_v;
   logic [N-1:0]       sc_res;
   logic               sc_zero, sc_neg, sc_ovf, sc_carry;
   logic               iter_go;

   always_comb begin
      sum_ext  = {1'b0, a} + {1'b0, b};
      diff_ext = {1'b0, a} - {1'b0, b};
      shamt    = b[SW-1:0];
      sh_big   = {1'b0, shamt} >= (SW+1)'(N);
      sra_v    = $signed(a) >>> shamt;
      sc_res   = '0;
      sc_ovf   = 1'b0;
      sc_carry = 1'b0;
      case (ctrl)
         OP_ADD: begin
            sc_res   = sum_ext[N-1:0];
            sc_carry = sum_ext[N];
            sc_ovf   = (a[N-1] == b[N-1]) && (sum_ext[N-1] != a[N-1]);
         end
         OP_SUB: begin
            sc_res   = diff_ext[N-1:0];
            sc_carry = diff_ext[N];
            sc_ovf   = (a[N-1] != b[N-1]) && (diff_ext[N-1] != a[N-1]);
         end
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         OP_NOTA: sc_res = ~a;
         OP_SHL:  sc_res = sh_big ? '0 : (a << shamt);
         OP_SHR:  sc_res = sh_big ? '0 : (a >> shamt);
         OP_SRA:  sc_res = sh_big ? {N{a[N-1]}} : sra_v;
         OP_EQ:   sc_res = {N{a == b}};
         OP_LTU:  sc_res = {N{a < b}};
         OP_GTU:  sc_res = {N{a > b}};
         OP_SLT:  sc_res = {N{$signed(a) < $signed(b)}};
         OP_DIVU, OP_REMU: sc_ovf = 1'b1;   // only reaches the outputs when b == 0
         default: sc_res = '0;
      endcase
      sc_neg  = (ctrl == OP_SUB) ? ($signed(a) < $signed(b)) : sc_res[N-1];
      sc_zero = (sc_res == '0);
      iter_go = (ctrl == OP_MUL) || (((ctrl == OP_DIVU) || (ctrl == OP_REMU)) && (b != '0));
   end

   logic [N:0]   mul_sum, div_sh;
   logic         div_ge;
   logic [N-1:0] div_sub;
   logic [N-1:0] hi_d, lo_d, fin_res, fin_hi;
   logic         fin_zero;

   // mul: {hi,lo} is the shifting product; div: hi is the partial remainder, lo the quotient
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_sh  = {hi_q, lo_q[N-1]};
      div_ge  = (div_sh >= {1'b0, b_q});
      div_sub = div_sh[N-1:0] - b_q;
      if (op_q == OP_MUL) begin
         hi_d = mul_sum[N:1];
         lo_d = {mul_sum[0], lo_q[N-1:1]};
      end else begin
         hi_d = div_ge ? div_sub : div_sh[N-1:0];
         lo_d = {lo_q[N-2:0], div_ge};
      end
      fin_res = lo_d;
      fin_hi  = hi_d;
      if (op_q == OP_REMU) begin
         fin_res = hi_d;
         fin_hi  = '0;
      end
      fin_zero = (op_q == OP_MUL) ? ({hi_d, lo_d} == '0) : (fin_res == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         op_q        <= '0;
         b_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         ovf_q       <= 1'b0;
         carry_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  op_q       <= ctrl;
                  b_q        <= b;
                  hi_q       <= '0;
                  lo_q       <= a;
                  cnt_q      <= SW'(N-1);
                  if (iter_go) begin
                     state_q <= S_BUSY;
                  end else begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= sc_res;
                     result_hi_q <= '0;
                     zero_q      <= sc_zero;
                     neg_q       <= sc_neg;
                     ovf_q       <= sc_ovf;
                     carry_q     <= sc_carry;
                  end
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            S_BUSY: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q - SW'(1);
               if (cnt_q == '0) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= fin_res;
                  result_hi_q <= fin_hi;
                  zero_q      <= fin_zero;
                  neg_q       <= fin_res[N-1];
                  ovf_q       <= 1'b0;
                  carry_q     <= 1'b0;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign zero      = zero_q;
   assign negative  = neg_q;
   assign overflow  = ovf_q;
   assign carry     = carry_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc at N=8 against an integer-arithmetic
// reference model.
module tb_alu_mc;
   localparam int N = 8;

   logic         clk, rst_n;
   logic         in_valid, in_ready;
   logic [N-1:0] a, b;
   logic [3:0]   ctrl;
   logic         out_valid, out_ready;
   logic [N-1:0] result, result_hi;
   logic         zero, negative, overflow, carry;

   int n_checks = 0;
   int n_errors = 0;

   alu_mc #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ctrl(ctrl),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi),
      .zero(zero), .negative(negative), .overflow(overflow), .carry(carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input int op, input int ua, input int ub,
                                 output int r, output int rh, output int z, output int ng,
                                 output int ov, output int cy, output int lat);
      int sa, sb, t, p;
      sa = (ua > 127) ? ua - 256 : ua;
      sb = (ub > 127) ? ub - 256 : ub;
      r = 0; rh = 0; ov = 0; cy = 0; lat = 1; p = 0;
      case (op)
         0:  begin t = ua + ub; r = t % 256; cy = t / 256; t = sa + sb; ov = (t > 127 || t < -128); end
         1:  begin r = (ua - ub + 256) % 256; cy = (ua < ub); t = sa - sb; ov = (t > 127 || t < -128); end
         2:  r = ua & ub;
         3:  r = ua | ub;
         4:  r = ua ^ ub;
         5:  r = 255 - ua;
         6:  r = (ua << (ub % 8)) % 256;
         7:  r = ua >> (ub % 8);
         8:  r = (sa >>> (ub % 8)) & 255;
         9:  r = (ua == ub) ? 255 : 0;
         10: r = (ua < ub) ? 255 : 0;
         11: r = (ua > ub) ? 255 : 0;
         12: begin p = ua * ub; r = p % 256; rh = p / 256; lat = 9; end
         13: if (ub == 0) ov = 1; else begin r = ua / ub; rh = ua % ub; lat = 9; end
         14: if (ub == 0) ov = 1; else begin r = ua % ub; lat = 9; end
         default: r = (sa < sb) ? 255 : 0;
      endcase
      ng = (op == 1) ? int'(sa < sb) : int'(r >= 128);
      z  = (op == 12) ? int'(p == 0) : int'(r == 0);
   endfunction

   task automatic check_outputs(input string tag, input int r, input int rh, input int z,
                                input int ng, input int ov, input int cy);
      check_val({tag, " result"}, 32'(result), r);
      check_val({tag, " result_hi"}, 32'(result_hi), rh);
      check_val({tag, " flags zncv"}, {28'd0, zero, negative, overflow, carry},
                {28'd0, z[0], ng[0], ov[0], cy[0]});
   endtask

   // Issue one request, time its latency, optionally hold it in DONE (poking a
   // second request meanwhile), then consume it.
   task automatic run_op(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                         input int hold, input bit poke);
      int r, rh, z, ng, ov, cy, elat, lat, w;
      string tag;
      tag = $sformatf("op%0d a=%0h b=%0h", op, va, vb);
      model(int'(op), int'(va), int'(vb), r, rh, z, ng, ov, cy, elat);
      w = 0;
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      check_val({tag, " ready timeout"}, 32'(w < 50), 1);
      in_valid = 1'b1; a = va; b = vb; ctrl = op;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); ctrl = 4'($urandom);
      lat = 1;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      check_val({tag, " latency"}, 32'(lat), elat);
      check_outputs(tag, r, rh, z, ng, ov, cy);
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); ctrl = 4'($urandom_range(0, 11));
         end
         @(posedge clk); #1;
         check_val({tag, " hold valid"}, 32'(out_valid), 1);
         check_val({tag, " hold in_ready"}, 32'(in_ready), 0);
         check_outputs({tag, " hold"}, r, rh, z, ng, ov, cy);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val({tag, " valid after take"}, 32'(out_valid), 0);
      check_val({tag, " ready after take"}, 32'(in_ready), 1);
      if (poke) begin
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val({tag, " poked req ignored"}, 32'(out_valid), 0);
         end
      end
   endtask

   int d_op[13] = '{0, 1, 1, 12, 12, 13, 14, 13, 6, 7, 8, 15, 10};
   int d_a[13]  = '{8'h7F, 8'h05, 8'h80, 8'hFF, 8'h10, 200, 200, 8'h55, 8'h96, 8'h96, 8'h96, 8'h80, 8'h80};
   int d_b[13]  = '{8'h01, 8'h07, 8'h01, 8'hFF, 8'h10, 7, 7, 0, 3, 3, 3, 1, 1};

   initial begin
      bit saw_valid;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; ctrl = '0;
      #12;
      check_val("reset in_ready", 32'(in_ready), 0);
      check_val("reset out_valid", 32'(out_valid), 0);
      check_outputs("reset", 0, 0, 0, 0, 0, 0);
      @(negedge clk); rst_n = 1'b1; #1;
      check_val("in_ready before first edge", 32'(in_ready), 0);
      @(posedge clk); #1;
      check_val("in_ready after first edge", 32'(in_ready), 1);

      for (int i = 0; i < 13; i++)
         run_op(4'(d_op[i]), 8'(d_a[i]), 8'(d_b[i]), 0, 1'b0);

      run_op(4'd4, 8'h3C, 8'h0F, 5, 1'b1);
      run_op(4'd12, 8'hC3, 8'h5A, 5, 1'b1);

      // reset in the middle of a multiply
      while (!in_ready) begin @(posedge clk); #1; end
      in_valid = 1'b1; a = 8'hAB; b = 8'hCD; ctrl = 4'd12;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("midrst out_valid", 32'(out_valid), 0);
      check_val("midrst in_ready", 32'(in_ready), 0);
      check_outputs("midrst", 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 1'b0;
      repeat (15) begin @(posedge clk); #1; if (out_valid) saw_valid = 1'b1; end
      check_val("midrst no stale result", 32'(saw_valid), 0);
      run_op(4'd0, 8'h12, 8'h34, 0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         logic [7:0] rb;
         rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         run_op(4'($urandom_range(0, 15)), 8'($urandom), rb, $urandom_range(0, 2), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end
endmodule
